// File: rtl/uart_fifo_ext.sv
// uart_fifo_ext: parametrised UART FIFO with level counts, thresholds, FWFT mode,
// flush, sticky error flags, high-watermark and per-word parity.
module uart_fifo_ext #(
    parameter int FIFO_DW   = 8,
    parameter int FIFO_AW   = 4,
    parameter int PARITY_EN = 1,
    parameter int FWFT      = 0
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_flush,
    input  logic               i_wr_req,
    input  logic [FIFO_DW-1:0] i_data_in,
    input  logic               i_rd_req,
    input  logic [FIFO_AW:0]   i_afull_thr,
    input  logic [FIFO_AW:0]   i_aempty_thr,
    input  logic               i_err_clr,
    output logic [FIFO_DW-1:0] o_data_out,
    output logic               o_valid,
    output logic [FIFO_AW:0]   o_used,
    output logic [FIFO_AW:0]   o_free,
    output logic [FIFO_AW:0]   o_max_used,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_almost_full,
    output logic               o_almost_empty,
    output logic               o_overflow,
    output logic               o_underflow,
    output logic               o_parity_error
);
    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(1) << FIFO_AW;

    logic [FIFO_DW-1:0]    mem_q [2**FIFO_AW];
    logic [2**FIFO_AW-1:0] par_q;
    logic [FIFO_AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [FIFO_AW:0]      used_q, used_d, max_q, max_d;
    logic [FIFO_DW-1:0]    data_q, data_d, head;
    logic                  valid_q, valid_d, perr_q, perr_d, ovf_q, ovf_d, unf_q, unf_d;
    logic                  rd, wr, empty, full, head_perr;

    assign empty     = used_q == '0;
    assign full      = used_q == DEPTH;
    assign rd        = !i_flush & i_rd_req & !empty;
    assign wr        = !i_flush & i_wr_req & (!full | rd);
    assign head      = mem_q[rp_q];
    assign head_perr = PARITY_EN != 0 && ((^head) != par_q[rp_q]);

    always_comb begin
        wp_d    = i_flush ? '0 : wp_q + FIFO_AW'(wr);
        rp_d    = i_flush ? '0 : rp_q + FIFO_AW'(rd);
        used_d  = i_flush ? '0 : used_q + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(rd);
        // Watermark restarts from the current level when cleared
        max_d   = (i_flush | i_err_clr) ? used_d : (used_d > max_q ? used_d : max_q);
        ovf_d   = (!i_flush & i_wr_req & !wr) | (ovf_q & !i_err_clr);
        unf_d   = (!i_flush & i_rd_req & empty) | (unf_q & !i_err_clr);
        data_d  = rd ? head : data_q;
        valid_d = rd;
        perr_d  = rd & head_perr;
    end

    always_ff @(posedge i_clk) begin
        if (wr) begin
            mem_q[wp_q] <= i_data_in;
            par_q[wp_q] <= PARITY_EN != 0 && (^i_data_in);
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            used_q  <= '0;
            max_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            used_q  <= used_d;
            max_q   <= max_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign o_data_out     = FWFT != 0 ? (empty ? '0 : head) : data_q;
    assign o_valid        = FWFT != 0 ? !empty : valid_q;
    assign o_parity_error = FWFT != 0 ? (!empty & head_perr) : perr_q;
    assign o_used         = used_q;
    assign o_free         = DEPTH - used_q;
    assign o_max_used     = max_q;
    assign o_full         = full;
    assign o_empty        = empty;
    assign o_almost_full  = used_q >= i_afull_thr;
    assign o_almost_empty = used_q <= i_aempty_thr;
    assign o_overflow     = ovf_q;
    assign o_underflow    = unf_q;
endmodule

// File: tb/tb_uart_fifo_ext.sv
// tb_uart_fifo_ext: registered (u0) and show-ahead (u1) FIFOs of depth 4 driven in lockstep,
// checked against a word scoreboard and a small level/flag model.
module tb_uart_fifo_ext;
    logic       clk = 1'b0, nrst = 1'b0, flush = 1'b0, wr_req = 1'b0, rd_req = 1'b0, err_clr = 1'b0;
    logic [7:0] din = '0;
    logic [2:0] athr = 3'd3, ethr = 3'd1;
    logic [7:0] d0, d1;
    logic [2:0] used0, used1, free0, free1, max0, max1;
    logic       v0, v1, full0, full1, empty0, empty1, af0, af1, ae0, ae1;
    logic       ovf0, ovf1, unf0, unf1, pe0, pe1;

    int         total = 0, bad = 0, m_used = 0;
    bit         m_ovf = 0, m_unf = 0, exp_pe0 = 0, exp_pe1 = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    uart_fifo_ext #(.FIFO_DW(8), .FIFO_AW(2), .PARITY_EN(1), .FWFT(0)) u0 (
        .i_clk(clk), .i_nrst(nrst), .i_flush(flush), .i_wr_req(wr_req), .i_data_in(din),
        .i_rd_req(rd_req), .i_afull_thr(athr), .i_aempty_thr(ethr), .i_err_clr(err_clr),
        .o_data_out(d0), .o_valid(v0), .o_used(used0), .o_free(free0), .o_max_used(max0),
        .o_full(full0), .o_empty(empty0), .o_almost_full(af0), .o_almost_empty(ae0),
        .o_overflow(ovf0), .o_underflow(unf0), .o_parity_error(pe0));

    uart_fifo_ext #(.FIFO_DW(8), .FIFO_AW(2), .PARITY_EN(1), .FWFT(1)) u1 (
        .i_clk(clk), .i_nrst(nrst), .i_flush(flush), .i_wr_req(wr_req), .i_data_in(din),
        .i_rd_req(rd_req), .i_afull_thr(athr), .i_aempty_thr(ethr), .i_err_clr(err_clr),
        .o_data_out(d1), .o_valid(v1), .o_used(used1), .o_free(free1), .o_max_used(max1),
        .o_full(full1), .o_empty(empty1), .o_almost_full(af1), .o_almost_empty(ae1),
        .o_overflow(ovf1), .o_underflow(unf1), .o_parity_error(pe1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_used", used0, 0);
        chk("rst_free", free0, 4);
        chk("rst_max", max0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_aempty", ae0, 1);
        chk("rst_data0", d0, 0);
        chk("rst_valid0", v0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_unf", unf0, 0);
        chk("rst_valid1", v1, 0);
        chk("rst_data1", d1, 0);
    endtask

    // One clock of stimulus; the model predicts acceptance and every output is compared after the edge
    task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit fl = 0, input bit ec = 0);
        bit mr, mw;
        logic [7:0] popped;
        popped = '0;
        mr = !fl && r && m_used != 0;
        mw = !fl && w && (m_used != 4 || mr);
        m_ovf = (!fl && w && !mw) || (m_ovf && !ec);
        m_unf = (!fl && r && m_used == 0) || (m_unf && !ec);
        if (fl) begin
            sb.delete();
            m_used = 0;
        end
        if (mr) begin
            popped = sb.pop_front();
            m_used--;
        end
        if (mw) begin
            sb.push_back(d);
            m_used++;
        end
        wr_req = w; din = d; rd_req = r; flush = fl; err_clr = ec;
        tick();
        wr_req = 0; rd_req = 0; flush = 0; err_clr = 0;
        chk("used0", used0, m_used);
        chk("used1", used1, m_used);
        chk("free", free0, 4 - m_used);
        chk("empty", empty0, m_used == 0);
        chk("full", full0, m_used == 4);
        chk("afull", af0, m_used >= int'(athr));
        chk("aempty", ae0, m_used <= int'(ethr));
        chk("ovf", ovf0, m_ovf);
        chk("unf", unf0, m_unf);
        chk("valid0", v0, mr);
        if (mr) chk("data0", d0, popped);
        chk("valid1", v1, m_used != 0);
        chk("data1", d1, m_used != 0 ? sb[0] : 8'h00);
        chk("perr0", pe0, exp_pe0);
        chk("perr1", pe1, exp_pe1);
    endtask

    initial begin
        #2;
        chk_reset();
        #10;
        nrst = 1'b1;
        // Fill, overflow, drain
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h11 * (i + 1)), 0);
        chk("max_full", max0, 4);
        cyc(1, 8'h55, 0);
        cyc(0, 8'h00, 0);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        // Read+write while full, then read+write while empty
        cyc(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h11 * (i + 1)), 0);
        cyc(1, 8'h99, 1);
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1);
        cyc(1, 8'h77, 1);
        cyc(0, 8'h00, 1);
        // Show-ahead single word with extreme thresholds
        athr = 3'd0;
        ethr = 3'd4;
        cyc(0, 8'h00, 0, 0, 1);
        cyc(1, 8'hA5, 0);
        cyc(0, 8'h00, 1);
        athr = 3'd3;
        ethr = 3'd1;
        // Flush with concurrent requests, then clear racing a new underflow
        for (int i = 1; i <= 3; i++) cyc(1, 8'(i), 0);
        chk("max_three", max0, 3);
        cyc(1, 8'hEE, 1, 1, 0);
        chk("max_flush", max0, 0);
        cyc(0, 8'h00, 1, 0, 1);
        chk("unf_set_wins", unf0, 1);
        cyc(0, 8'h00, 0, 0, 1);
        // Corrupt the stored parity of the word at address 0
        cyc(1, 8'h5A, 0);
        u0.par_q <= u0.par_q ^ 4'b0001;
        u1.par_q <= u1.par_q ^ 4'b0001;
        #1;
        chk("perr1_head", pe1, 1);
        chk("perr0_idle", pe0, 0);
        exp_pe0 = 1;
        cyc(0, 8'h00, 1);
        exp_pe0 = 0;
        cyc(0, 8'h00, 0);
        // Asynchronous reset in the middle of a write burst
        cyc(0, 8'h00, 1);
        cyc(1, 8'h10, 0);
        cyc(1, 8'h20, 0);
        wr_req = 1;
        din = 8'h30;
        #3;
        nrst = 1'b0;
        #1;
        chk_reset();
        sb.delete();
        m_used = 0;
        m_ovf = 0;
        m_unf = 0;
        wr_req = 0;
        nrst = 1'b1;
        cyc(1, 8'hC3, 0);
        cyc(0, 8'h00, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
